// File: rtl/gs_butterfly_pipe.sv
// gs_butterfly_pipe: 3-stage Gentleman-Sande butterfly for the Kyber INTT, with valid/ready and full-pipeline stall.
module gs_butterfly_pipe #(
  parameter int Q = 3329,
  parameter int W = 12,
  parameter int BARRETT_M = 5039,
  parameter int BARRETT_SHIFT = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] zeta_in,
  input  logic         last_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         last_out
);
  localparam int PW = 2 * W;
  localparam int XW = PW + 16;
  logic          en, v1, v2, l1, l2;
  logic [W-1:0]  sum1, diff1, z1, sum2, sum_c, diff_c, b_c;
  logic [W:0]    s_raw, d_raw, s_sub, d_add;
  logic [PW-1:0] prod2, t, r0, r1;
  logic [XW-1:0] bm;
  assign en = !(out_valid && !out_ready);
  assign in_ready = en;
  // Barrett quotient undershoots by at most 2, so two conditional subtractions always land in [0,Q)
  always_comb begin
    s_raw  = {1'b0, a_in} + {1'b0, b_in};
    d_raw  = {1'b0, a_in} - {1'b0, b_in};
    s_sub  = s_raw - (W+1)'(Q);
    d_add  = d_raw + (W+1)'(Q);
    sum_c  = s_raw >= (W+1)'(Q) ? s_sub[W-1:0] : s_raw[W-1:0];
    diff_c = a_in < b_in ? d_add[W-1:0] : d_raw[W-1:0];
    bm     = XW'(prod2) * XW'(BARRETT_M);
    t      = PW'(bm >> BARRETT_SHIFT);
    r0     = prod2 - t * PW'(Q);
    r1     = r0 >= PW'(Q) ? r0 - PW'(Q) : r0;
    b_c    = W'(r1 >= PW'(Q) ? r1 - PW'(Q) : r1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      last_out  <= 1'b0;
      sum1      <= '0;
      diff1     <= '0;
      z1        <= '0;
      sum2      <= '0;
      prod2     <= '0;
      a_out     <= '0;
      b_out     <= '0;
    end else if (en) begin
      v1        <= in_valid;
      sum1      <= sum_c;
      diff1     <= diff_c;
      z1        <= zeta_in;
      l1        <= last_in;
      v2        <= v1;
      prod2     <= PW'(diff1) * PW'(z1);
      sum2      <= sum1;
      l2        <= l1;
      out_valid <= v2;
      a_out     <= sum2;
      b_out     <= b_c;
      last_out  <= l2;
    end
  end
endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// tb_gs_butterfly_pipe: directed and random checks of gs_butterfly_pipe against a queue-based arithmetic model.
module tb_gs_butterfly_pipe;
  localparam int Q = 3329;
  localparam int W = 12;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, last_in = 1'b0, out_valid, out_ready = 1'b1, last_out;
  logic [W-1:0] a_in = '0, b_in = '0, zeta_in = '0, a_out, b_out;
  int total = 0, bad = 0, accepted = 0, popped = 0, adv = 0;
  typedef struct {int a; int b; int z; int l; int adv;} beat_t;
  beat_t q[$];
  logic pv = 1'b0, pl;
  int pa, pb;

  gs_butterfly_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .zeta_in(zeta_in), .last_in(last_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .last_out(last_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted beat is due after three advancing (unstalled) edges.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pv = 1'b0;
    end else begin
      chk("out_valid", int'(out_valid), int'(q.size() > 0 && adv - q[0].adv == 3));
      chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (pv) begin
        chk("hold_a", int'(a_out), pa);
        chk("hold_b", int'(b_out), pb);
        chk("hold_last", int'(last_out), int'(pl));
      end
      if (out_valid && q.size() > 0) begin
        chk("model_a", int'(a_out), (q[0].a + q[0].b) % Q);
        chk("model_b", int'(b_out), ((q[0].a - q[0].b + Q) % Q) * q[0].z % Q);
        chk("model_last", int'(last_out), q[0].l);
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{int'(a_in), int'(b_in), int'(zeta_in), int'(last_in), adv});
        accepted++;
      end
      if (in_ready) adv++;
      pv = out_valid && !out_ready;
      pa = int'(a_out);
      pb = int'(b_out);
      pl = last_out;
    end
  end

  task automatic send(input int a, input int b, input int z, input int l);
    int n = 0;
    in_valid = 1'b1;
    a_in = W'(a);
    b_in = W'(b);
    zeta_in = W'(z);
    last_in = 1'(l);
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("send_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input int a, input int b, input int z, input int l, input int ea, input int eb);
    int n = 0;
    send(a, b, z, l);
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("dir_latency", n, 3);
    chk("dir_a", int'(a_out), ea);
    chk("dir_b", int'(b_out), eb);
    chk("dir_last", int'(last_out), l);
    @(negedge clk);
    chk("dir_pulse", int'(out_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] ov;
    int idx, stall_cnt, base, start, cyc;
    bit acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_a", int'(a_out), 0);
    chk("rst_b", int'(b_out), 0);
    chk("rst_last", int'(last_out), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    directed(5, 3, 17, 1, 8, 34);
    directed(3, 5, 1, 0, 8, 3327);
    directed(3328, 3328, 3328, 1, 3327, 0);
    directed(3000, 1, 3328, 0, 3001, 330);
    directed(3328, 0, 3328, 1, 3328, 1);
    directed(100, 7, 0, 0, 107, 0);
    directed(0, 0, 0, 1, 0, 0);

    base = popped;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      a_in = W'(c * 400 + 1);
      b_in = W'(3328 - c * 100);
      zeta_in = W'(c * 37 + 5);
      last_in = (c == 7);
      @(negedge clk);
      ov[c] = out_valid;
      @(posedge clk); #1;
    end
    chk("stream_pattern", int'(ov), int'(14'b00011111111000));
    chk("stream_count", popped - base, 8);

    base = popped;
    idx = 0;
    stall_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 5 && c < 9);
      in_valid = (idx < 6);
      a_in = W'(idx * 500);
      b_in = W'(idx * 7 + 1);
      zeta_in = W'(3000 - idx);
      last_in = (idx == 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) stall_cnt++;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    out_ready = 1'b1;
    chk("bp_stall_cycles", stall_cnt, 4);
    chk("bp_accepted", idx, 6);
    chk("bp_delivered", popped - base, 6);
    chk("bp_queue_empty", q.size(), 0);

    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a_in = W'(c + 10);
      b_in = W'(c + 20);
      zeta_in = W'(c + 30);
      last_in = 1'b0;
      rst = (c == 2);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush_out_valid", int'(out_valid), 0);
      chk("flush_in_ready", int'(in_ready), 1);
    end
    @(posedge clk); #1;
    directed(1, 1, 2, 0, 2, 0);

    start = accepted;
    cyc = 0;
    while (accepted - start < 10000 && cyc < 40000) begin
      in_valid = ($urandom_range(99) < 85);
      a_in = W'($urandom_range(Q - 1));
      b_in = W'($urandom_range(Q - 1));
      zeta_in = W'($urandom_range(Q - 1));
      last_in = 1'($urandom_range(1));
      out_ready = ($urandom_range(99) < 80);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("sweep_count", accepted - start, 10000);
    repeat (6) @(posedge clk);
    #1;
    chk("sweep_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
